// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - in-order instruction fetch unit with redirect flush and decode buffer
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode
);

    localparam int          PW        = $clog2(DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] pending_q, pending_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_pc_q [DEPTH];
    logic [31:0]   fifo_pc_d [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];

    logic          accept;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW:0]   slots_used;
    logic [31:0]   target_pc;
    logic [31:0]   head_instr;

    // Request gate and decode-side presentation; outstanding requests plus
    // buffered words never exceed DEPTH so a response always has a slot.
    always_comb begin
        fifo_empty = (count_q == '0);
        slots_used = {1'b0, pending_q} + {1'b0, count_q};
        imem_req   = !reset && !redirect && (slots_used < DEPTH_LIM);
        imem_addr  = fetch_pc_q;
        id_valid   = !fifo_empty && !redirect;
        head_instr = fifo_empty ? NOP_INSTR : fifo_instr_q[rd_ptr_q];
        id_instr   = head_instr;
        id_pc      = fifo_empty ? 32'h0000_0000 : fifo_pc_q[rd_ptr_q];
        id_opcode  = head_instr[6:0];
    end

    // Next-state for fetch/response counters and the instruction buffer.
    always_comb begin
        accept    = imem_req && imem_ready;
        resp_fire = imem_rvalid && (pending_q != '0);
        pop       = id_valid && id_ready;
        push      = resp_fire && !redirect && (discard_q == '0);
        target_pc = {redirect_pc[31:2], 2'b00};

        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        pending_d    = pending_q;
        discard_d    = discard_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;

        if (accept && !resp_fire) begin
            pending_d = pending_q + CW'(1);
        end else if (!accept && resp_fire) begin
            pending_d = pending_q - CW'(1);
        end

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect) begin
            // Every still-outstanding response belongs to the old stream;
            // one arriving this very cycle is dropped outright.
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            discard_d  = pending_d;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
        end else begin
            if (resp_fire && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                fifo_pc_d[wr_ptr_q]    = resp_pc_q;
                fifo_instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d               = wr_ptr_q + PW'(1);
                resp_pc_d              = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers; reset abandons any in-flight responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            pending_q  <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            pending_q  <= pending_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Buffer storage needs no reset; occupancy alone marks valid entries.
    always_ff @(posedge clk) begin
        fifo_pc_q    <= fifo_pc_d;
        fifo_instr_q <= fifo_instr_d;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the instruction buffer entries (power of two, 2..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-007 The block SHALL have port imem_ready, input, 1 bit: request accepted when imem_req && imem_ready.
REQ-008 The block SHALL have port imem_rvalid, input, 1 bit: response valid; responses arrive in order, at least 1 cycle after acceptance.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: response instruction word.
REQ-010 The block SHALL have port redirect, input, 1 bit: branch/jump taken; flush and refetch.
REQ-011 The block SHALL have port redirect_pc, input, 32 bits: new fetch target.
REQ-012 The block SHALL have port id_valid, output, 1 bit: instruction available to decode.
REQ-013 The block SHALL have port id_ready, input, 1 bit: decode accepts; transfer on id_valid && id_ready.
REQ-014 The block SHALL have port id_instr, output, 32 bits: head instruction.
REQ-015 The block SHALL have port id_pc, output, 32 bits: address of id_instr.
REQ-016 The block SHALL have port id_opcode, output, 7 bits: id_instr[6:0], for the decode controller.

Function
REQ-017 The block SHALL keep counters fetch_pc, resp_pc, pending (accepted, unanswered), discard (pending to drop) and an occupancy-counted DEPTH-entry FIFO of {pc, instr}.
REQ-018 The block SHALL assert imem_req = !reset && !redirect && (pending + occupancy < DEPTH), with imem_addr = fetch_pc.
REQ-019 The block SHALL, on acceptance, advance fetch_pc by 4 (mod 2^32 wrap) and increment pending.
REQ-020 The block SHALL, on imem_rvalid with pending > 0, decrement pending; if discard > 0, drop the word and decrement discard; else push {resp_pc, imem_rdata} and advance resp_pc by 4.
REQ-021 The block SHALL ignore imem_rvalid when pending == 0.
REQ-022 The block SHALL, on redirect, load fetch_pc and resp_pc with {redirect_pc[31:2], 2'b00}, empty the FIFO, and set discard to (pending - imem_rvalid), the same-cycle response itself being dropped.
REQ-023 The block SHALL drive id_valid = (occupancy != 0) && !redirect; a transfer pops the head; an offered-but-redirected cycle is not a transfer.
REQ-024 The block SHALL allow a push and a pop in the same cycle with occupancy unchanged; the request gate is never bypassed, so overflow cannot occur.
REQ-025 The block SHALL drive id_instr = 32'h0000_0013 (NOP), id_pc = 0, and id_opcode = 7'b0010011 while the FIFO is empty.
REQ-026 The block SHALL present a response word on id_* no earlier than the cycle after its imem_rvalid (no bypass).

Reset
REQ-027 The block SHALL, while reset is high, hold fetch_pc = resp_pc = RESET_PC, pending = discard = 0, FIFO empty, imem_req = 0, id_valid = 0, and id_* at NOP values.
REQ-028 The block SHALL issue its first request (address RESET_PC) in the first cycle after reset deasserts; reset mid-operation abandons outstanding responses without discard tracking.

Verification
REQ-029 The bench SHALL cover reset release with DEPTH=2, memory always ready, 1-cycle latency, id_ready=1 -> requests 0x0, 0x4, 0x8 ..., id_pc follows the same sequence, first id_valid in cycle 3.
REQ-030 The bench SHALL cover id_ready=0 with memory ready -> exactly 2 requests (0x0, 0x4), imem_req low afterward, id_pc=0x0 held stable.
REQ-031 The bench SHALL cover redirect to 0x1002 with 2 pending -> the next request is 0x1000, the 2 old responses are dropped, the first id_pc is 0x1000.
REQ-032 The bench SHALL cover redirect coincident with imem_rvalid and 1 pending -> the response is dropped, discard = 0, the next delivered word is at redirect target.
REQ-033 The bench SHALL cover redirect_pc = 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000 (wrap).
REQ-034 The bench SHALL cover an empty FIFO -> id_valid=0, id_instr=0x00000013, id_opcode=0x13; an imem_rvalid with pending=0 causes no push.
